cfu_mac_initiator: RTL

Command-side initiator for the CFU command/response protocol. The block accepts operand pairs from a host-side stream into a small FIFO and issues them one at a time to a CFU. It sums the returned products into a 32-bit accumulator and reports the sum and the element count when the group marked `last` completes. It sits between a DMA/sequencer and a multiply CFU, and it detects a non-responding CFU with a response timeout.

---
 rtl/cfu_pkg.sv | 22 ++
 rtl/cfu_cmd_fifo.sv | 50 +++++
 rtl/cfu_mac_initiator.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cfu_pkg.sv
// Shared types for the CFU command initiator: FSM states, payload widths and the queued command entry.
package cfu_pkg;

  localparam int CFU_FUNC_ID_W = 10;
  localparam int CFU_DATA_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_REPORT   = 3'd4
  } init_state_t;

  typedef struct packed {
    logic [CFU_FUNC_ID_W-1:0] function_id;
    logic [CFU_DATA_W-1:0]    op0;
    logic [CFU_DATA_W-1:0]    op1;
    logic                     last;
  } cfu_cmd_entry_t;

endpackage

// File: rtl/cfu_cmd_fifo.sv
// Synchronous FIFO of generic entries; read data is the registered head, one cycle from write to visible.
// Writes are refused when full unless a pop happens in the same cycle; reads of an empty FIFO are ignored.
module cfu_cmd_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  entry_t                   wr_data,
  input  logic                     rd_en,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/cfu_mac_initiator.sv
// Queues operand pairs, issues them one at a time to a multiply CFU and reports the summed group on 'last'.
// Command appears 2 cycles after a FIFO write; in_ready drops when the FIFO is full, REPORT holds until out_ready.
module cfu_mac_initiator import cfu_pkg::*; #(
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_W     = 16,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CFU_FUNC_ID_W-1:0] in_function_id,
  input  logic [CFU_DATA_W-1:0]    in_op0,
  input  logic [CFU_DATA_W-1:0]    in_op1,
  input  logic                     in_last,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [CFU_FUNC_ID_W-1:0] cmd_payload_function_id,
  output logic [CFU_DATA_W-1:0]    cmd_payload_inputs_0,
  output logic [CFU_DATA_W-1:0]    cmd_payload_inputs_1,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [CFU_DATA_W-1:0]    rsp_payload_outputs_0,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CFU_DATA_W-1:0]    out_sum,
  output logic [COUNT_W-1:0]       out_count,
  output logic                     out_error,
  output logic                     busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);

  init_state_t          state, state_nxt;
  logic [CFU_DATA_W-1:0] acc, acc_nxt;
  logic [COUNT_W-1:0]   count, count_nxt;
  logic                 err, err_nxt;
  logic                 pend_last, pend_last_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_nxt;
  logic                 active;

  cfu_cmd_entry_t       wr_entry;
  cfu_cmd_entry_t       head;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W-1:0]     fifo_cnt_nxt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;

  // active gates the handshakes so both read 0 while reset is held.
  assign in_ready  = active && !fifo_full;
  assign rsp_ready = active;
  assign fifo_push = in_valid && in_ready;

  assign wr_entry.function_id = in_function_id;
  assign wr_entry.op0         = in_op0;
  assign wr_entry.op1         = in_op1;
  assign wr_entry.last        = in_last;

  cfu_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (cfu_cmd_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_push),
    .wr_data (wr_entry),
    .rd_en   (fifo_pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_cnt_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    count_nxt     = count;
    err_nxt       = err;
    pend_last_nxt = pend_last;
    tmo_nxt       = tmo_cnt;
    fifo_pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          fifo_pop      = 1'b1;
          pend_last_nxt = head.last;
          tmo_nxt       = '0;
          state_nxt     = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          acc_nxt   = acc + rsp_payload_outputs_0;
          count_nxt = (&count) ? count : count + COUNT_W'(1);
          if (pend_last)        state_nxt = ST_REPORT;
          else if (!fifo_empty) state_nxt = ST_ISSUE;
          else                  state_nxt = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = pend_last ? ST_REPORT : ST_DRAIN;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      ST_DRAIN: begin
        // Discard the rest of the failed group, including entries still arriving.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.last) state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (out_ready) begin
          acc_nxt   = '0;
          count_nxt = '0;
          err_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= ST_IDLE;
      acc                     <= '0;
      count                   <= '0;
      err                     <= 1'b0;
      pend_last               <= 1'b0;
      tmo_cnt                 <= '0;
      active                  <= 1'b0;
      cmd_valid               <= 1'b0;
      cmd_payload_function_id <= '0;
      cmd_payload_inputs_0    <= '0;
      cmd_payload_inputs_1    <= '0;
      out_valid               <= 1'b0;
      out_sum                 <= '0;
      out_count               <= '0;
      out_error               <= 1'b0;
      busy                    <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      count     <= count_nxt;
      err       <= err_nxt;
      pend_last <= pend_last_nxt;
      tmo_cnt   <= tmo_nxt;
      active    <= 1'b1;
      cmd_valid <= (state_nxt == ST_ISSUE);
      // Payload is captured once on entry to ISSUE and then held until accepted.
      if (state_nxt == ST_ISSUE && state != ST_ISSUE) begin
        cmd_payload_function_id <= head.function_id;
        cmd_payload_inputs_0    <= head.op0;
        cmd_payload_inputs_1    <= head.op1;
      end
      out_valid <= (state_nxt == ST_REPORT);
      if (state_nxt == ST_REPORT && state != ST_REPORT) begin
        out_sum   <= acc_nxt;
        out_count <= count_nxt;
        out_error <= err_nxt;
      end
      busy <= (state_nxt != ST_IDLE) || (fifo_cnt_nxt != '0);
    end
  end

endmodule
